// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  // Active-low digit enables: all ones turns every digit off.
  localparam logic [MAX_DIGITS-1:0] DIGITS_OFF = '1;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_slot_timer.sv
// Slot counter and digit index for the display scanner; flags slot end, frame wrap
// and whether the cycle after the coming edge falls inside the guard window.
module display_slot_timer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             slot_end,
  output logic             frame_wrap,
  output logic             in_guard
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Wraps are explicit compares so non-power-of-two sizes behave.
  assign slot_end   = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_wrap = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
  assign cnt_next   = slot_end ? '0 : cnt + CNT_W'(1);

  // Looks ahead one cycle so the scanner state lines up with cnt after the edge.
  assign in_guard = (GUARD_CYCLES != 0) && (cnt_next < CNT_W'(GUARD_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      if (slot_end) begin
        idx <= frame_wrap ? '0 : idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed hex display scanner with double-buffered value and guard interval.
// Optional DISPLAY_LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int VALUE_W = NIBBLE_W * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  output logic                  ready,
  output logic [NIBBLE_W-1:0]   digit_code,
  output logic                  blank,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_done
);

  logic [IDX_W-1:0]   idx;
  logic               slot_end;
  logic               frame_wrap;
  logic               in_guard;
  scan_state_t        state;
  logic [VALUE_W-1:0] active;
  logic [VALUE_W-1:0] pending;
  logic               pending_valid;

  function automatic logic [NIBBLE_W-1:0] nibble_at(input logic [VALUE_W-1:0] v,
                                                    input logic [IDX_W-1:0]   i);
    logic [NIBBLE_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (i == IDX_W'(k)) n = v[k*NIBBLE_W +: NIBBLE_W];
    end
    return n;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] enable_for(input logic [IDX_W-1:0] i);
    logic [NUM_DIGITS-1:0] sel;
    sel = DIGITS_OFF[NUM_DIGITS-1:0];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (i == IDX_W'(k)) sel[k] = 1'b0;
    end
    return sel;
  endfunction

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  // True when digit i and every digit above it are zero; digit 0 always shows.
  function automatic logic leading_zero(input logic [VALUE_W-1:0] v,
                                        input logic [IDX_W-1:0]   i);
    logic nonzero;
    nonzero = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IDX_W'(k) >= i) && (v[k*NIBBLE_W +: NIBBLE_W] != '0)) nonzero = 1'b1;
    end
    return (i != '0) && !nonzero;
  endfunction
`endif

  display_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .slot_end  (slot_end),
    .frame_wrap(frame_wrap),
    .in_guard  (in_guard)
  );

  // Scan FSM: state mirrors the current slot position; outputs lag it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= (GUARD_CYCLES == 0) ? SHOW : GUARD;
      digit_sel  <= DIGITS_OFF[NUM_DIGITS-1:0];
      blank      <= 1'b1;
      digit_code <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        GUARD: if (!in_guard) state <= SHOW;
        SHOW:  if (slot_end && in_guard) state <= GUARD;
      endcase

      frame_done <= frame_wrap;
      // The code is presented during guard too, so the converter settles early.
      digit_code <= nibble_at(active, idx);

      if (state == SHOW) begin
        digit_sel <= enable_for(idx);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        blank     <= leading_zero(active, idx);
`else
        blank     <= 1'b0;
`endif
      end else begin
        digit_sel <= DIGITS_OFF[NUM_DIGITS-1:0];
        blank     <= 1'b1;
      end
    end
  end

  // Double buffer: a pending value lands only on a frame wrap, so updates are tear-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      ready         <= 1'b1;
    end else if (load && ready) begin
      pending       <= value;
      pending_valid <= 1'b1;
      ready         <= 1'b0;
    end else if (frame_wrap && pending_valid) begin
      active        <= pending;
      pending_valid <= 1'b0;
      ready         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        ready;
  logic [3:0]  digit_code;
  logic        blank;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  // Edges since reset release; after edge k the outputs reflect slot position k-1.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  display_scan_controller #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .ready     (ready),
    .digit_code(digit_code),
    .blank     (blank),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_sel;
    int pos;
    int d;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 'h1);
    check("rst_sel", 32'(digit_sel), 'hF);
    check("rst_blank", 32'(blank), 'h1);
    check("rst_code", 32'(digit_code), 'h0);
    check("rst_fdone", 32'(frame_done), 'h0);
    rst = 1'b0;

    // Free run, first frame: 2 guard cycles then 6 show cycles per digit.
    for (int k = 1; k <= 32; k++) begin
      wait_until(k);
      pos = (k - 1) % 8;
      d   = (k - 1) / 8;
      exp_sel = (pos < 2) ? 4'hF : (4'hF & ~(4'h1 << d));
      check("run_sel", 32'(digit_sel), 32'(exp_sel));
      check("run_blank", 32'(blank), (pos < 2) ? 'h1 : 'h0);
      check("run_fdone", 32'(frame_done), (k == 32) ? 'h1 : 'h0);
      check("run_code", 32'(digit_code), 'h0);
    end
    wait_until(33);
    check("fdone_clear", 32'(frame_done), 'h0);

    // Mid-frame load of 1A3F, then an ignored load of FFFF.
    wait_until(40);
    pulse_load(16'h1A3F);
    check("load_ready0", 32'(ready), 'h0);
    wait_until(45);
    pulse_load(16'hFFFF);
    check("busy_ready0", 32'(ready), 'h0);
    wait_until(51);
    check("prewrap_code", 32'(digit_code), 'h0);
    wait_until(63);
    check("prewrap_ready", 32'(ready), 'h0);
    wait_until(64);
    check("copy_ready1", 32'(ready), 'h1);
    check("copy_fdone", 32'(frame_done), 'h1);
    wait_until(65);
    check("f_guard_code", 32'(digit_code), 'hF);
    check("f_guard_sel", 32'(digit_sel), 'hF);
    check("f_guard_blank", 32'(blank), 'h1);
    wait_until(67);
    check("d0_code", 32'(digit_code), 'hF);
    check("d0_sel", 32'(digit_sel), 'hE);
    wait_until(75);
    check("d1_code", 32'(digit_code), 'h3);
    check("d1_sel", 32'(digit_sel), 'hD);
    wait_until(83);
    check("d2_code", 32'(digit_code), 'hA);
    check("d2_sel", 32'(digit_sel), 'hB);
    wait_until(91);
    check("d3_code", 32'(digit_code), 'h1);
    check("d3_sel", 32'(digit_sel), 'h7);
    check("d3_blank", 32'(blank), 'h0);
    wait_until(99);
    check("nofff_code", 32'(digit_code), 'hF);

    // Load landing on the wrap edge: copied one frame later, not at this wrap.
    wait_until(127);
    pulse_load(16'h0042);
    check("wrapload_ready", 32'(ready), 'h0);
    check("wrapload_fdone", 32'(frame_done), 'h1);
    wait_until(131);
    check("old_frame_code", 32'(digit_code), 'hF);
    wait_until(159);
    check("wait_ready0", 32'(ready), 'h0);
    wait_until(160);
    check("wait_ready1", 32'(ready), 'h1);
    wait_until(163);
    check("new_d0_code", 32'(digit_code), 'h2);
    check("new_d0_sel", 32'(digit_sel), 'hE);
    wait_until(171);
    check("new_d1_code", 32'(digit_code), 'h4);
    check("new_d1_sel", 32'(digit_sel), 'hD);

    // Reset during digit 2 show with an update pending.
    wait_until(172);
    pulse_load(16'h7777);
    check("pend_ready0", 32'(ready), 'h0);
    wait_until(180);
    check("pre_rst_sel", 32'(digit_sel), 'hB);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sel", 32'(digit_sel), 'hF);
    check("midrst_ready", 32'(ready), 'h1);
    check("midrst_blank", 32'(blank), 'h1);
    check("midrst_code", 32'(digit_code), 'h0);
    rst = 1'b0;
    wait_until(3);
    check("postrst_code", 32'(digit_code), 'h0);
    check("postrst_sel", 32'(digit_sel), 'hE);
    wait_until(35);
    check("discard_code", 32'(digit_code), 'h0);
    check("discard_ready", 32'(ready), 'h1);

    // Leading-zero handling: 0042 then 0000.
    pulse_load(16'h0042);
    wait_until(67);
    check("lz42_d0_code", 32'(digit_code), 'h2);
    check("lz42_d0_blank", 32'(blank), 'h0);
    wait_until(75);
    check("lz42_d1_code", 32'(digit_code), 'h4);
    check("lz42_d1_blank", 32'(blank), 'h0);
    pulse_load(16'h0000);
    wait_until(83);
    check("lz42_d2_sel", 32'(digit_sel), 'hB);
    check("lz42_d2_blank", 32'(blank), 32'(LZ));
    wait_until(91);
    check("lz42_d3_sel", 32'(digit_sel), 'h7);
    check("lz42_d3_blank", 32'(blank), 32'(LZ));
    wait_until(99);
    check("lz0_d0_code", 32'(digit_code), 'h0);
    check("lz0_d0_blank", 32'(blank), 'h0);
    wait_until(107);
    check("lz0_d1_blank", 32'(blank), 32'(LZ));
    check("lz0_d1_sel", 32'(digit_sel), 'hD);
    wait_until(115);
    check("lz0_d2_blank", 32'(blank), 32'(LZ));
    wait_until(123);
    check("lz0_d3_blank", 32'(blank), 32'(LZ));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
